// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive/transmit blocks.
// Holds the receiver state encoding, parity mode constants and a
// constant-evaluable ceil(log2) used to size counters.
package uart_pkg;

    // Receiver frame states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_t;

    // Parity modes
    localparam int PAR_NONE = 32'sd0;
    localparam int PAR_ODD  = 32'sd1;
    localparam int PAR_EVEN = 32'sd2;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        while ((32'd1 << result) < 32'(value)) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input bit.
// RESET_VAL sets the value both flops take during reset, so an idle-high
// serial line does not look like a start bit right after reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with mid-bit sampling.
// The rx pin is synchronised by sync_2ff; all decoding uses the synchronised
// copy. Each completed character is presented on a valid/ready interface
// together with frame and parity error flags; a completed frame that cannot
// be delivered because the consumer is still holding the previous one is
// dropped and recorded in the sticky overrun flag.
// Optional feature: define UART_RX_MATCH_EN to add parameter MATCH_CHAR and
// a one-cycle match pulse for error-free frames equal to MATCH_CHAR.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
`ifdef UART_RX_MATCH_EN
    ,
    parameter logic [8:0] MATCH_CHAR = 9'h030
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
`ifdef UART_RX_MATCH_EN
    output logic                 match,
`endif
    output logic                 busy
);

    localparam int CNT_W = clog2(CLKS_PER_BIT);
    localparam int IDX_W = clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] BIT_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    logic                 rx_s;
    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr_acc;
    logic                 perr_acc;
    logic                 ferr_final;

    // Parity check on the received data plus the sampled parity bit
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] data,
                                        input logic                 pbit);
        logic ones_odd;
        ones_odd = (^data) ^ pbit;
        if (PARITY == PAR_EVEN) begin
            return ones_odd;
        end else begin
            return ~ones_odd;
        end
    endfunction

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

    // The frame error including the stop bit being sampled right now
    assign ferr_final = ferr_acc | ~rx_s;

    // Frame FSM, sampling counters, output register and handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            ferr_acc   <= 1'b0;
            perr_acc   <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_MATCH_EN
            match      <= 1'b0;
`endif
        end else begin
            // Consumer takes the character: valid drops next cycle unless
            // a new frame completes in this same cycle (handled below).
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
`ifdef UART_RX_MATCH_EN
            match <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    cnt      <= '0;
                    bit_idx  <= '0;
                    ferr_acc <= 1'b0;
                    perr_acc <= 1'b0;
                    if (!rx_s) begin
                        state <= ST_START;
                        busy  <= 1'b1;
                    end
                end

                ST_START: begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= ST_DATA;
                        end else begin
                            // Glitch shorter than half a bit: ignore it
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                ST_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_idx == BIT_LAST) begin
                            bit_idx <= '0;
                            state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_ONE;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                ST_PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt      <= '0;
                        perr_acc <= parity_bad(shreg, rx_s);
                        state    <= ST_STOP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                ST_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            // Deliver, or drop and flag overrun if the
                            // previous character is still unaccepted.
                            if (!rx_valid || rx_ready) begin
                                rx_data    <= shreg;
                                frame_err  <= ferr_final;
                                parity_err <= perr_acc;
                                rx_valid   <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
`ifdef UART_RX_MATCH_EN
                            match <= (shreg == MATCH_CHAR[DATA_BITS-1:0]) &&
                                     !ferr_final && !perr_acc;
`endif
                            // A low line here is a break: wait for idle
                            if (rx_s) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= ST_WAIT_HIGH;
                                busy  <= 1'b1;
                            end
                        end else begin
                            bit_idx  <= bit_idx + IDX_ONE;
                            ferr_acc <= ferr_final;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                ST_WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: self-checking bench for uart_rx_param.
// Two receivers share the clock and reset: dut_a is 8N1, dut_b is 8 data
// bits, even parity, two stop bits. Frames are built from line levels and
// the expected character/flags are derived from those levels directly.
module tb_uart_rx_param;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       rdy_a = 1'b1, rdy_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       va, vb, fa, fb, pa, pb, oa, ob, ba, bb;
`ifdef UART_RX_MATCH_EN
    logic       ma, mb;
`endif

    int n_pass = 0;
    int n_chk  = 0;
    int vcnt_a = 0;
    logic [9:0] q_a[$];
    logic [9:0] q_b[$];

    always #5 clk = ~clk;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .rx_data(data_a), .rx_valid(va),
        .rx_ready(rdy_a), .frame_err(fa), .parity_err(pa), .overrun(oa),
`ifdef UART_RX_MATCH_EN
        .match(ma),
`endif
        .busy(ba)
    );

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .rx_data(data_b), .rx_valid(vb),
        .rx_ready(rdy_b), .frame_err(fb), .parity_err(pb), .overrun(ob),
`ifdef UART_RX_MATCH_EN
        .match(mb),
`endif
        .busy(bb)
    );

    // Record each accepted character and count valid cycles
    always @(negedge clk) begin
        if (va && rdy_a) q_a.push_back({fa, pa, data_a});
        if (vb && rdy_b) q_b.push_back({fb, pb, data_b});
        if (va) vcnt_a <= vcnt_a + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_line(input int which, input logic level, input int cycles);
        if (which == 0) rx_a = level; else rx_b = level;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Line levels of one frame, start bit first (bit 0)
    function automatic logic [15:0] mk_bits(input int which, input logic [7:0] d,
                                            input logic pbit, input logic [1:0] stops);
        if (which == 0) return {6'd0, stops[0], d, 1'b0};
        else            return {4'd0, stops[1], stops[0], pbit, d, 1'b0};
    endfunction

    // Expected {frame_err, parity_err, data} computed from the frame rules
    function automatic logic [9:0] exp_of(input int which, input logic [7:0] d,
                                          input logic pbit, input logic [1:0] stops);
        int ones;
        ones = $countones({d, pbit});
        if (which == 0) return {~stops[0], 1'b0, d};
        else            return {~(stops[0] & stops[1]), (ones % 2 == 1), d};
    endfunction

    task automatic drive_frame(input int which, input logic [7:0] d,
                               input logic pbit, input logic [1:0] stops);
        logic [15:0] bits;
        int n;
        bits = mk_bits(which, d, pbit, stops);
        n = (which == 0) ? 10 : 12;
        for (int i = 0; i < n; i++) drive_line(which, bits[i], CPB);
        drive_line(which, 1'b1, 2 * CPB);
    endtask

    task automatic get_check(input int which, input string tag, input logic [9:0] exp);
        bit ok;
        logic [9:0] got;
        ok = 1'b0;
        for (int i = 0; i < 8 * CPB && !ok; i++) begin
            ok = (which == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
            if (!ok) @(negedge clk);
        end
        check_val({tag, "_arrived"}, 32'(ok), 32'd1);
        if (ok) begin
            got = (which == 0) ? q_a.pop_front() : q_b.pop_front();
            check_val(tag, 32'(got), 32'(exp));
        end
    endtask

    initial begin
        int v0;
        logic [7:0] d;
        logic       pbit;
        logic [1:0] stops;
        logic [9:0] bits5a;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_a", {va, fa, pa, oa, ba, data_a}, 32'd0);
        check_val("reset_b", {vb, fb, pb, ob, bb, data_b}, 32'd0);
        rst = 1'b0;
        drive_line(0, 1'b1, 4);

        // 8N1 0x30 with ready high: one valid cycle, clean flags
        v0 = vcnt_a;
        drive_frame(0, 8'h30, 1'b0, 2'b11);
        get_check(0, "char_30", exp_of(0, 8'h30, 1'b0, 2'b11));
        check_val("valid_1cyc", 32'(vcnt_a - v0), 32'd1);

        // Short low glitch: no character, receiver returns idle
        v0 = vcnt_a;
        drive_line(0, 1'b0, CPB / 4);
        drive_line(0, 1'b1, 2 * CPB);
        check_val("glitch_noval", 32'(vcnt_a - v0), 32'd0);
        check_val("glitch_busy", 32'(ba), 32'd0);
        drive_frame(0, 8'hA5, 1'b0, 2'b11);
        get_check(0, "char_a5", exp_of(0, 8'hA5, 1'b0, 2'b11));

        // Even parity: 0x07 with parity 0 is bad, with parity 1 is good
        drive_frame(1, 8'h07, 1'b0, 2'b11);
        get_check(1, "par_bad", exp_of(1, 8'h07, 1'b0, 2'b11));
        drive_frame(1, 8'h07, 1'b1, 2'b11);
        get_check(1, "par_good", exp_of(1, 8'h07, 1'b1, 2'b11));

        // Break: one zero frame with frame error, nothing more until high
        v0 = vcnt_a;
        drive_line(0, 1'b0, 12 * CPB);
        check_val("break_one", 32'(vcnt_a - v0), 32'd1);
        check_val("break_busy", 32'(ba), 32'd1);
        drive_line(0, 1'b0, 4 * CPB);
        check_val("break_hold", 32'(vcnt_a - v0), 32'd1);
        drive_line(0, 1'b1, 2 * CPB);
        check_val("break_idle", 32'(ba), 32'd0);
        get_check(0, "break_chr", exp_of(0, 8'h00, 1'b0, 2'b00));

        // Overrun: second frame dropped while first is unaccepted
        rdy_a = 1'b0;
        drive_frame(0, 8'h11, 1'b0, 2'b11);
        drive_frame(0, 8'h22, 1'b0, 2'b11);
        check_val("ovr_data", 32'(data_a), 32'h11);
        check_val("ovr_valid", 32'(va), 32'd1);
        check_val("ovr_flag", 32'(oa), 32'd1);
        rdy_a = 1'b1;
        drive_line(0, 1'b1, 1);
        check_val("ovr_vdrop", 32'(va), 32'd0);
        check_val("ovr_sticky", 32'(oa), 32'd1);
        get_check(0, "ovr_chr", exp_of(0, 8'h11, 1'b0, 2'b11));

        // Reset during the 4th data bit of 0x5A
        bits5a = mk_bits(0, 8'h5A, 1'b0, 2'b11);
        for (int i = 0; i < 4; i++) drive_line(0, bits5a[i], CPB);
        drive_line(0, bits5a[4], CPB / 2);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_mid", {va, fa, pa, oa, ba, data_a}, 32'd0);
        drive_line(0, 1'b1, 1);
        rst = 1'b0;
        v0 = vcnt_a;
        drive_line(0, 1'b1, 12 * CPB);
        check_val("rst_noval", 32'(vcnt_a - v0), 32'd0);
        drive_frame(0, 8'h5A, 1'b0, 2'b11);
        get_check(0, "char_5a", exp_of(0, 8'h5A, 1'b0, 2'b11));
        check_val("rst_ovr_clr", 32'(oa), 32'd0);

        // Randomised frames on both receivers
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            stops = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b11;
            drive_frame(0, d, 1'b0, stops);
            get_check(0, "rand_a", exp_of(0, d, 1'b0, stops));
        end
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            pbit = 1'($urandom);
            stops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            drive_frame(1, d, pbit, stops);
            get_check(1, "rand_b", exp_of(1, d, pbit, stops));
        end
        check_val("no_ovr_b", 32'(ob), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
